// File: rtl/vga_pkg.sv
// Shared definitions for the VGA output path: channel width, sync idle level,
// filter mode encodings and the RGB444 pixel type.
package vga_pkg;

   localparam int   CW            = 4;
   localparam logic SYNC_IDLE_LVL = 1'b1;

   localparam logic MODE_PASS = 1'b0;
   localparam logic MODE_BLUR = 1'b1;

   typedef struct packed {
      logic [CW-1:0] r;
      logic [CW-1:0] g;
      logic [CW-1:0] b;
   } rgb_t;

endpackage

// File: rtl/tap3_blur.sv
// One colour channel of the [1 2 1]/4 horizontal kernel, round half-up.
// Purely combinational; edge replication is resolved by the caller.
module tap3_blur #(
   parameter int CW = 4
) (
   input  logic [CW-1:0] l,
   input  logic [CW-1:0] c,
   input  logic [CW-1:0] r,
   output logic [CW-1:0] y
);

   logic [CW+1:0] sum;

   // Worst case 4*max+2 still fits in CW+2 bits, so the shifted result never exceeds max.
   assign sum = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r} + (CW+2)'(2);
   assign y   = CW'(sum >> 2);

endmodule

// File: rtl/vga_line_filter.sv
// Per-line 3-tap horizontal smoothing in front of the VGA pins. Fixed 2-clock
// pipeline for pixels, DE and syncs; mode only changes at a vsync leading edge.
module vga_line_filter
   import vga_pkg::*;
#(
   parameter int   CW        = vga_pkg::CW,
   parameter logic SYNC_IDLE = SYNC_IDLE_LVL
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          func,
   input  logic          de_in,
   input  logic          hsync_in,
   input  logic          vsync_in,
   input  logic [CW-1:0] r_in,
   input  logic [CW-1:0] g_in,
   input  logic [CW-1:0] b_in,
   output logic          de_out,
   output logic          hsync_out,
   output logic          vsync_out,
   output logic [CW-1:0] r_out,
   output logic [CW-1:0] g_out,
   output logic [CW-1:0] b_out
);

   // Channel index: 0 = red, 1 = green, 2 = blue.
   logic [2:0][CW-1:0] s0_px, s1_px, s2_px;
   logic [2:0][CW-1:0] left_px, right_px, blur_px, px_next;
   logic               s0_v, s1_v, s2_v;
   logic               hs0, hs1, vs0, vs1;
   logic               mode;
   logic               mode_armed;
   logic               vsync_start;

   assign vsync_start = (vsync_in != SYNC_IDLE) && (vs0 == SYNC_IDLE);

   for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      tap3_blur #(.CW(CW)) u_blur (
         .l (left_px[ch]),
         .c (s1_px[ch]),
         .r (right_px[ch]),
         .y (blur_px[ch])
      );
   end

   // Neighbours outside the current line are replaced by the centre pixel.
   always_comb begin
      left_px  = s2_v ? s2_px : s1_px;
      right_px = s0_v ? s0_px : s1_px;
      px_next  = '0;
      if (s1_v) begin
         px_next = (mode == MODE_BLUR) ? blur_px : s1_px;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_px      <= '0;
         s1_px      <= '0;
         s2_px      <= '0;
         s0_v       <= 1'b0;
         s1_v       <= 1'b0;
         s2_v       <= 1'b0;
         hs0        <= SYNC_IDLE;
         hs1        <= SYNC_IDLE;
         vs0        <= SYNC_IDLE;
         vs1        <= SYNC_IDLE;
         hsync_out  <= SYNC_IDLE;
         vsync_out  <= SYNC_IDLE;
         de_out     <= 1'b0;
         r_out      <= '0;
         g_out      <= '0;
         b_out      <= '0;
         mode       <= MODE_PASS;
         mode_armed <= 1'b1;
      end else begin
         s0_px      <= {b_in, g_in, r_in};
         s0_v       <= de_in;
         s1_px      <= s0_px;
         s1_v       <= s0_v;
         s2_px      <= s1_px;
         s2_v       <= s1_v;
         hs0        <= hsync_in;
         hs1        <= hs0;
         hsync_out  <= hs1;
         vs0        <= vsync_in;
         vs1        <= vs0;
         vsync_out  <= vs1;
         de_out     <= s1_v;
         r_out      <= px_next[0];
         g_out      <= px_next[1];
         b_out      <= px_next[2];
         // First cycle out of reset takes func directly; afterwards only a frame start does.
         if (mode_armed || vsync_start) begin
            mode <= func;
         end
         mode_armed <= 1'b0;
      end
   end

endmodule

// File: doc/vga_line_filter.md
# vga_line_filter

Streaming per-line 3-tap horizontal smoothing stage for RGB444 VGA video. Sits directly upstream of the VGA output pins, between the pixel source/timing generator and the `red_out`/`green_out`/`blue_out`/`hsync_out`/`vsync_out` ports of `top`. `func` selects passthrough or a [1 2 1]/4 blur per colour channel. Sync and blanking are delayed to stay aligned with the filtered pixels.

## Interface

Parameters:
- `CW`, 4: bits per colour channel.
- `SYNC_IDLE`, 1: inactive level of `hsync`/`vsync`. The 640x480 syncs are negative, so idle is 1.

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `func`  in  1  mode select: 0 = passthrough, 1 = [1 2 1]/4 horizontal blur.
- `de_in`  in  1  pixel valid (active video) from the timing generator.
- `hsync_in`  in  1  horizontal sync from the timing generator.
- `vsync_in`  in  1  vertical sync from the timing generator.
- `r_in`, `g_in`, `b_in`  in  CW each  input pixel.
- `de_out`  out  1  delayed `de_in`.
- `hsync_out`, `vsync_out`  out  1 each  delayed syncs.
- `r_out`, `g_out`, `b_out`  out  CW each  filtered pixel; 0 when `de_out`=0.

## Operation

- Three-deep pixel shift register per channel:
  - `s0` holds the newest pixel, `s1` the centre pixel, `s2` the oldest.
  - Each stage carries its own valid bit, copied from `de_in`.
  - The register shifts every cycle, with no stall.
- Output pixel is computed from the centre `s1`, with neighbours L = `s2` and R = `s0`.
- Edge replication:
  - If `s2` is invalid (first pixel of a line), L = `s1`.
  - If `s0` is invalid (last pixel of a line), R = `s1`.
  - If both are invalid (a 1-pixel line), the output equals `s1`.
- Blur arithmetic per channel: (L + 2·C + R + 2) >> 2.
  - Intermediate width is CW+2 bits.
  - The maximum is 4·15+2 = 62, so the result is at most 15; no saturation logic is needed.
  - Rounding is half-up.
- Passthrough (mode 0): output = C.
- Blanking: when the centre valid bit is 0, `r_out`/`g_out`/`b_out` = 0 regardless of mode.
- Mode latch:
  - `func` is sampled into an internal `mode` register only on the cycle where `vsync_in` transitions from `SYNC_IDLE` to active.
  - A mode change therefore never splits a frame.
  - After reset, `mode` = `func` sampled on the first cycle out of reset.
- No state machine beyond the mode latch. Behaviour is a fixed pipeline.

## Timing

- Latency is exactly 2 clocks for every signal.
  - Inputs sampled at edge k appear on all outputs after edge k+2.
  - `de_out`, `hsync_out`, `vsync_out` pass through the same 2-stage delay as the pixel centre, so the relative alignment at the input is preserved.
- Outputs are registered. There is no combinational path from input to output.
- During reset, and on the cycle reset is released:
  - colour outputs = 0
  - `de_out` = 0
  - `hsync_out` = `vsync_out` = `SYNC_IDLE`
  - all pipeline valid bits = 0
- Reset mid-frame:
  - The pipeline is flushed.
  - The first 2 output cycles after release hold reset values.
  - No stale pixel is emitted.
- Each `de_in` rising edge starts a new line. Pixels across the blanking gap are never mixed, because replication is keyed on the per-stage valid bits.
- `func` toggling when no vsync edge occurs has no effect on the output.

## Structure

- Shared package `vga_pkg`:
  - `CW`
  - sync idle level
  - mode encodings `MODE_PASS` = 0, `MODE_BLUR` = 1
  - RGB444 pixel typedef: a struct of three CW-bit fields
- Sub-module `tap3_blur`: one channel, combinational (L, C, R) → result, instantiated three times.
- Pipeline registers, valid bits, sync delay and mode latch stay in `vga_line_filter`.

## Test plan

- **Reset:** hold `rst`=1 for 5 cycles with random inputs → all colour outputs 0, `de_out`=0, syncs=1 on every cycle. After release, the first valid output appears exactly 2 cycles after the first `de_in`=1.
- **Passthrough:** `func`=0 across a vsync edge, line of pixels R=0,5,10,15 → `r_out`=0,5,10,15, delayed by 2 cycles, with `de_out` matching.
- **Blur interior:** `func`=1 latched, line R=0,4,8,12 → `r_out`:
  - 1 (edge, L=0)
  - 4
  - 8
  - 11 (edge, R=12: (8+24+12+2)>>2 = 11)
- **Max value:** all channels 15 across a full 640-pixel line in blur mode → every output 15, with no wrap.
- **Mode boundary:** assert `func`=1 mid-frame → output remains passthrough until the next `vsync_in` active edge, then the blur applies from the first line of the new frame.
- **Line separation and reset:** line ending with pixel 15 followed by blanking, then a line starting with 0 → the first pixel of the new line outputs 0, with no bleed. Pulse `rst` mid-line → 2 cycles of reset values, then clean restart.
